// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, sequencer
// states and the operand/writeback/ALU select codes used by the datapath.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] A_RS1  = 2'b00;
    localparam logic [1:0] A_PC   = 2'b01;
    localparam logic [1:0] A_ZERO = 2'b10;

    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    function automatic logic opc_legal(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: opc_legal = 1'b1;
            default:                               opc_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct to ALU operation map. Only OP and OP_IMM pick a
// funct-derived operation; every other class uses the adder.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OPC_OP:     alu_op = {funct7_5, funct3};
            // instr[30] is part of the immediate for OP_IMM except on shift-right
            OPC_OP_IMM: alu_op = {funct7_5 & (funct3 == 3'b101), funct3};
            default:    alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky HALT on
// unsupported opcodes. Owns the single memory request/ready handshake.
module multicycle_control
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic [1:0] a_sel,
    output logic [1:0] b_sel,
    output logic [3:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       pc_write,
    output logic       pc_sel,
    output logic       illegal,
    output logic [2:0] state_dbg
);

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       taken_q, taken_d;
    logic [3:0] dec_alu_op;

    alu_decoder u_alu_decoder (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_op   (dec_alu_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            taken_q   <= taken_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        taken_d      = taken_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        a_sel        = A_RS1;
        b_sel        = B_RS2;
        alu_op       = ALU_ADD;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opc_legal(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OPC_OP: begin
                        a_sel = A_RS1;
                        b_sel = B_RS2;
                    end
                    OPC_BRANCH, OPC_JAL, OPC_AUIPC: begin
                        a_sel = A_PC;
                        b_sel = B_IMM;
                    end
                    OPC_LUI: begin
                        a_sel = A_ZERO;
                        b_sel = B_IMM;
                    end
                    default: begin
                        a_sel = A_RS1;
                        b_sel = B_IMM;
                    end
                endcase
                alu_op  = dec_alu_op;
                taken_d = branch_taken;
                state_d = (opcode == OPC_LOAD || opcode == OPC_STORE) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OPC_STORE);
                if (mem_ready) begin
                    // a store retires here, so it owns the PC update
                    if (opcode == OPC_STORE) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_write = 1'b1;
                case (opcode)
                    OPC_LOAD: begin
                        reg_write = 1'b1;
                        wb_sel    = WB_MEM;
                    end
                    OPC_JAL, OPC_JALR: begin
                        reg_write = 1'b1;
                        wb_sel    = WB_PC4;
                        pc_sel    = 1'b1;
                    end
                    OPC_BRANCH: pc_sel = taken_q;
                    default:    reg_write = 1'b1;
                endcase
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // the state register may still hold a mid-access state during reset
        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_write     = 1'b0;
            a_sel        = A_RS1;
            b_sel        = B_RS2;
            alu_op       = ALU_ADD;
            reg_write    = 1'b0;
            wb_sel       = WB_ALU;
            pc_write     = 1'b0;
            pc_sel       = 1'b0;
        end
    end

    assign illegal   = illegal_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle trace model built from instruction
// class rules, a directed vector table, random instructions and corner sequences.
module tb_multicycle_control;

    localparam logic [6:0] T_OP = 7'b0110011, T_OPI = 7'b0010011, T_LD = 7'b0000011,
                           T_ST = 7'b0100011, T_BR = 7'b1100011, T_JAL = 7'b1101111,
                           T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_write;
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic [3:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       pc_write;
        logic       pc_sel;
        logic       illegal;
        logic [2:0] state;
    } outs_t;

    typedef struct {
        logic  rdy;
        outs_t e;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f75;
        logic       tk;
        int         fw;
        int         mw;
        logic [3:0] e_alu;
        int         e_cyc;
        logic       e_rw;
        logic [1:0] e_wb;
        logic       e_pcs;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0, branch_taken = 1'b0, mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, reg_write, pc_write, pc_sel, illegal;
    logic [1:0] a_sel, b_sel, wb_sel;
    logic [3:0] alu_op;
    logic [2:0] state_dbg;
    outs_t      act;

    cyc_t       q[$];
    vec_t       tbl[14];
    logic [6:0] ops[9];
    int         ncmp = 0, nerr = 0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
        .a_sel(a_sel), .b_sel(b_sel), .alu_op(alu_op), .reg_write(reg_write),
        .wb_sel(wb_sel), .pc_write(pc_write), .pc_sel(pc_sel), .illegal(illegal),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign act = {mem_req, mem_we, mem_addr_sel, ir_write, a_sel, b_sel, alu_op,
                  reg_write, wb_sel, pc_write, pc_sel, illegal, state_dbg};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        ncmp++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    function automatic outs_t blank(input logic [2:0] st);
        outs_t o;
        o = '0;
        o.state = st;
        return o;
    endfunction

    // Expected cycle-by-cycle trace of one instruction, from the class rules.
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input logic tk, input int fw, input int mw);
        cyc_t c;
        logic ld, st;
        ld = (op == T_LD);
        st = (op == T_ST);
        q.delete();
        for (int i = 0; i <= fw; i++) begin
            c.rdy = (i == fw);
            c.e = blank(3'd0);
            c.e.mem_req = 1'b1;
            c.e.ir_write = (i == fw);
            q.push_back(c);
        end
        c.rdy = 1'($urandom);
        c.e = blank(3'd1);
        q.push_back(c);
        c.rdy = 1'($urandom);
        c.e = blank(3'd2);
        case (op)
            T_OP:                 begin c.e.a_sel = 2'b00; c.e.b_sel = 2'b00; end
            T_BR, T_JAL, T_AUIPC: begin c.e.a_sel = 2'b01; c.e.b_sel = 2'b01; end
            T_LUI:                begin c.e.a_sel = 2'b10; c.e.b_sel = 2'b01; end
            default:              begin c.e.a_sel = 2'b00; c.e.b_sel = 2'b01; end
        endcase
        if (op == T_OP) c.e.alu_op = {f75, f3};
        else if (op == T_OPI) c.e.alu_op = (f3 == 3'b101) ? {f75, f3} : {1'b0, f3};
        q.push_back(c);
        if (ld || st) begin
            for (int i = 0; i <= mw; i++) begin
                c.rdy = (i == mw);
                c.e = blank(3'd3);
                c.e.mem_req = 1'b1;
                c.e.mem_addr_sel = 1'b1;
                c.e.mem_we = st;
                c.e.pc_write = st && (i == mw);
                q.push_back(c);
            end
        end
        if (!st) begin
            c.rdy = 1'($urandom);
            c.e = blank(3'd4);
            c.e.pc_write = 1'b1;
            c.e.reg_write = (op != T_BR);
            c.e.wb_sel = ld ? 2'b01 : (op == T_JAL || op == T_JALR) ? 2'b10 : 2'b00;
            c.e.pc_sel = (op == T_JAL || op == T_JALR) ? 1'b1 : (op == T_BR) ? tk : 1'b0;
            q.push_back(c);
        end
    endtask

    // Runs one instruction from FETCH back to FETCH, checking every cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                             input logic tk, input int fw, input int mw,
                             output int cyc, output logic [3:0] alu, output int pw,
                             output logic rw, output logic [1:0] wb, output logic pcs);
        logic left;
        left = 1'b0; cyc = 0; alu = '0; pw = 0; rw = 1'b0; wb = '0; pcs = 1'b0;
        build(op, f3, f75, tk, fw, mw);
        opcode = op; funct3 = f3; funct7_5 = f75;
        while (cyc < 40) begin
            if (cyc < q.size()) begin
                mem_ready = q[cyc].rdy;
                case (q[cyc].e.state)
                    3'd2:    branch_taken = tk;
                    3'd4:    branch_taken = ~tk;
                    default: branch_taken = 1'($urandom);
                endcase
            end else begin
                mem_ready = 1'b1;
                branch_taken = 1'($urandom);
            end
            @(negedge clk);
            if (cyc < q.size())
                chk($sformatf("cycle op=%b c%0d", op, cyc), 32'(act), 32'(q[cyc].e));
            if (state_dbg == 3'd2) alu = alu_op;
            if (pc_write) begin pw++; wb = wb_sel; pcs = pc_sel; end
            if (reg_write) rw = 1'b1;
            if (state_dbg != 3'd0) left = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (left && state_dbg == 3'd0) break;
        end
        chk("back_in_fetch", 32'(left && state_dbg == 3'd0), 32'd1);
    endtask

    initial begin
        int cyc, pw, base, fw, mw;
        logic [3:0] alu;
        logic rw, pcs;
        logic [1:0] wb;
        logic [6:0] op;

        ops = '{T_OP, T_OPI, T_LD, T_ST, T_BR, T_JAL, T_JALR, T_LUI, T_AUIPC};
        //        op       f3      f75   tk    fw mw  alu      cyc rw    wb     pcs
        tbl[0]  = '{T_OP,   3'b000, 1'b0, 1'b0, 0, 0, 4'b0000, 4, 1'b1, 2'b00, 1'b0};
        tbl[1]  = '{T_OP,   3'b000, 1'b1, 1'b0, 0, 0, 4'b1000, 4, 1'b1, 2'b00, 1'b0};
        tbl[2]  = '{T_OPI,  3'b101, 1'b1, 1'b0, 0, 0, 4'b1101, 4, 1'b1, 2'b00, 1'b0};
        tbl[3]  = '{T_OPI,  3'b000, 1'b1, 1'b0, 0, 0, 4'b0000, 4, 1'b1, 2'b00, 1'b0};
        tbl[4]  = '{T_LD,   3'b010, 1'b0, 1'b0, 0, 3, 4'b0000, 8, 1'b1, 2'b01, 1'b0};
        tbl[5]  = '{T_ST,   3'b010, 1'b0, 1'b0, 0, 0, 4'b0000, 4, 1'b0, 2'b00, 1'b0};
        tbl[6]  = '{T_BR,   3'b000, 1'b0, 1'b1, 0, 0, 4'b0000, 4, 1'b0, 2'b00, 1'b1};
        tbl[7]  = '{T_BR,   3'b000, 1'b0, 1'b0, 0, 0, 4'b0000, 4, 1'b0, 2'b00, 1'b0};
        tbl[8]  = '{T_JAL,  3'b000, 1'b0, 1'b0, 0, 0, 4'b0000, 4, 1'b1, 2'b10, 1'b1};
        tbl[9]  = '{T_JALR, 3'b000, 1'b0, 1'b0, 0, 0, 4'b0000, 4, 1'b1, 2'b10, 1'b1};
        tbl[10] = '{T_LUI,  3'b000, 1'b1, 1'b0, 0, 0, 4'b0000, 4, 1'b1, 2'b00, 1'b0};
        tbl[11] = '{T_AUIPC,3'b111, 1'b1, 1'b0, 0, 0, 4'b0000, 4, 1'b1, 2'b00, 1'b0};
        tbl[12] = '{T_OP,   3'b111, 1'b0, 1'b0, 2, 0, 4'b0111, 6, 1'b1, 2'b00, 1'b0};
        tbl[13] = '{T_ST,   3'b000, 1'b0, 1'b0, 1, 2, 4'b0000, 7, 1'b0, 2'b00, 1'b0};

        // Reset: strobes low, state FETCH, illegal clear.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 32'(act), 32'(blank(3'd0)));
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].f75, tbl[i].tk, tbl[i].fw, tbl[i].mw,
                      cyc, alu, pw, rw, wb, pcs);
            chk($sformatf("vec%0d alu_op", i), 32'(alu), 32'(tbl[i].e_alu));
            chk($sformatf("vec%0d latency", i), 32'(cyc), 32'(tbl[i].e_cyc));
            chk($sformatf("vec%0d reg_write", i), 32'(rw), 32'(tbl[i].e_rw));
            chk($sformatf("vec%0d wb_sel", i), 32'(wb), 32'(tbl[i].e_wb));
            chk($sformatf("vec%0d pc_sel", i), 32'(pcs), 32'(tbl[i].e_pcs));
            chk($sformatf("vec%0d pc_write_count", i), 32'(pw), 32'd1);
        end

        for (int n = 0; n < 150; n++) begin
            op = ops[$urandom_range(0, 8)];
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            base = (op == T_LD) ? 5 + mw : (op == T_ST) ? 4 + mw : 4;
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), fw, mw,
                      cyc, alu, pw, rw, wb, pcs);
            chk($sformatf("rand%0d latency", n), 32'(cyc), 32'(base + fw));
            chk($sformatf("rand%0d pc_write_count", n), 32'(pw), 32'd1);
        end

        // Unsupported opcode: HALT forever, no requests, sticky illegal.
        opcode = 7'b1111111; funct3 = '0; funct7_5 = 1'b0; mem_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k >= 2)
                chk($sformatf("halt k%0d", k),
                    32'({state_dbg, illegal, mem_req, pc_write, reg_write, ir_write}),
                    32'({3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
            @(posedge clk); #1;
            mem_ready = 1'($urandom);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_halt strobes",
            32'({mem_req, mem_we, ir_write, reg_write, pc_write}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("after_halt_rst", 32'({state_dbg, illegal, mem_req}), 32'({3'd0, 1'b0, 1'b1}));
        @(posedge clk); #1;

        // Reset during a stalled load access.
        opcode = T_LD; funct3 = 3'b010; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("mem_wait k%0d", k),
                32'({state_dbg, mem_req, mem_addr_sel, mem_we}), 32'({3'd3, 1'b1, 1'b1, 1'b0}));
            if (k == 0) begin @(posedge clk); #1; end
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_mem strobes",
            32'({mem_req, mem_we, ir_write, reg_write, pc_write}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after_mem_rst", 32'({state_dbg, illegal, mem_req, reg_write}),
            32'({3'd0, 1'b0, 1'b1, 1'b0}));
        @(posedge clk); #1;

        run_instr(T_OP, 3'b000, 1'b0, 1'b0, 0, 0, cyc, alu, pw, rw, wb, pcs);
        chk("recover latency", 32'(cyc), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32I core datapath. It decodes the current opcode and steps each instruction through FETCH, DECODE, EXEC, MEM and WB. In every state it drives the operand-select, ALU-op, memory, register-file and PC-update controls. It sits beside the operand builder, ALU, register file and the shared instruction/data memory port, and owns the only memory request/ready handshake.

## Interface
Parameters:
- none; all encodings live in the shared package.

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0], from the instruction register.
- funct3  in  3  instr[14:12].
- funct7_5  in  1  instr[30].
- branch_taken  in  1  comparator result for the current branch funct3; valid in EXEC.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  store (write) access.
- mem_addr_sel  out  1  0 = pc, 1 = registered ALU result.
- ir_write  out  1  load instruction register.
- a_sel  out  2  00 rs1, 01 pc, 10 zero.
- b_sel  out  2  00 rs2, 01 imm, 10 constant 4.
- alu_op  out  4  ALU operation code.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  00 ALU result, 01 load data, 10 pc+4.
- pc_write  out  1  PC update enable.
- pc_sel  out  1  0 = pc+4, 1 = registered ALU result.
- illegal  out  1  unsupported opcode seen; sticky.
- state_dbg  out  3  current state encoding.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- **FETCH:**
  - mem_req=1, mem_addr_sel=0.
  - Holds until mem_ready; on that cycle ir_write=1 and the FSM goes to DECODE.
- **DECODE:**
  - All strobes are 0.
  - Classifies the opcode as OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI or AUIPC, then goes to EXEC.
  - Any other opcode goes to HALT.
- **EXEC operand/ALU selection:**
  - OP: rs1/rs2.
  - OP_IMM, LOAD, STORE, JALR: rs1/imm.
  - BRANCH, JAL, AUIPC: pc/imm.
  - LUI: zero/imm.
- **EXEC next state:** LOAD and STORE go to MEM; all others go to WB.
- **EXEC latch:** the branch_taken value is captured into an internal register.
- **alu_op:**
  - OP: {funct7_5, funct3}.
  - OP_IMM: {funct7_5 only when funct3=101, else 0; funct3}.
  - All others: ADD (0000).
- **MEM:**
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - Holds until mem_ready.
  - LOAD then goes to WB.
  - STORE asserts pc_write=1 with pc_sel=0 on the mem_ready cycle, then goes to FETCH.
- **WB:** single cycle, always pc_write=1, then FETCH.
  - OP, OP_IMM, LUI, AUIPC: reg_write=1, wb_sel=00, pc_sel=0.
  - LOAD: reg_write=1, wb_sel=01, pc_sel=0.
  - JAL, JALR: reg_write=1, wb_sel=10, pc_sel=1.
  - BRANCH: reg_write=0, pc_sel = latched taken.
- **HALT:**
  - illegal=1; all other strobes 0.
  - Remains in HALT until rst.
- Outputs are Moore-style decoded from state plus opcode/funct fields. Exception: ir_write and the STORE pc_write, which are also qualified by mem_ready.

## Timing
- **Reset:**
  - State=FETCH, illegal=0, latched taken=0.
  - All strobes are 0 during the rst cycle.
  - mem_req=1 from the first cycle after rst deasserts.
- **Latency with mem_ready tied high:**
  - OP, OP_IMM, LUI, AUIPC, BRANCH, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
- Each cycle mem_ready is low in FETCH or MEM adds exactly one cycle.
- **Handshake:**
  - mem_req stays high and mem_we/mem_addr_sel stay stable until mem_ready.
  - mem_ready outside FETCH/MEM is ignored.
- rst asserted in any state, including a pending memory wait, returns to FETCH next cycle and drops mem_req during the rst cycle.
- Exactly one pc_write pulse per retired instruction; never in HALT.
- opcode/funct inputs are stable from DECODE through WB, because the instruction register is written only in FETCH.

## Structure
- Package rv_ctrl_pkg holds:
  - 7-bit opcode constants (OP=0110011, OP_IMM=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, JALR=1100111, LUI=0110111, AUIPC=0010111).
  - State encodings.
  - a_sel, b_sel, wb_sel and alu_op encodings.
- The operand builder consumes the same a_sel/b_sel constants from this package.
- One natural sub-module: alu_decoder, a combinational map of opcode/funct3/funct7_5 to alu_op.

## Test plan
- add x3,x1,x2 (opcode 0110011, funct7_5=0), mem_ready=1 → FETCH, DECODE, EXEC (a_sel=00, b_sel=00, alu_op=0000), WB (reg_write=1, wb_sel=00, pc_write=1); back in FETCH at cycle 4.
- sub and srai (funct3=101, funct7_5=1 on OP_IMM) → alu_op=1000 and 1101. addi with instr[30]=1 → alu_op=0000.
- lw with mem_ready low for 3 cycles in MEM → mem_req held for 4 cycles, mem_addr_sel=1, mem_we=0; WB wb_sel=01; total 8 cycles.
- sw → MEM mem_we=1; pc_write=1 only on the mem_ready cycle; no WB state and no reg_write.
- beq with branch_taken=1, then again with 0 → WB pc_sel=1, then 0; reg_write=0 both times. jal → wb_sel=10, pc_sel=1.
- Opcode 1111111 → HALT, illegal=1, no further mem_req. rst pulse → FETCH with illegal=0. rst asserted mid-MEM wait → FETCH, no reg_write.
